dht22_multi_reader: RTL and testbench

//  Round-robin DHT22 single-wire reader for N_CH sensors sharing one protocol engine.

---
 rtl/dht22_multi_reader.sv | 236 +++++++++++++++++++++++
 tb/tb_dht22_multi_reader.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dht22_multi_reader.sv
`timescale 1ns/1ps
// Round-robin DHT22 reader: one protocol engine time-shared across N_CH open-drain sensor lines.
// Results are read combinationally via rd_ch; done pulses one cycle per channel transaction, no backpressure.
module dht22_multi_reader #(
  parameter int N_CH       = 4,
  parameter int CLK_FREQ   = 100_000_000,
  parameter int SIMULATION = 0,
  parameter int POLL_MS    = 2000,
  parameter int TIMEOUT_US = 200,
  parameter int BIT_TH_US  = 48,
  localparam int CHW       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            enable,
  input  logic [N_CH-1:0] ch_mask,
  inout  wire  [N_CH-1:0] dht22_in_out,
  input  logic [CHW-1:0]  rd_ch,
  output logic [15:0]     rd_humidity,
  output logic [15:0]     rd_temperature,
  output logic [7:0]      rd_crc,
  output logic [15:0]     rd_status,
  output logic            done,
  output logic [CHW-1:0]  done_ch
);

  localparam int US_DIV   = CLK_FREQ / 1_000_000;
  localparam int PW       = (US_DIV > 1) ? $clog2(US_DIV) : 1;
  localparam int POLL_US  = (SIMULATION != 0) ? 20_000 : POLL_MS * 1000;
  localparam int START_US = 1000;

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_SELECT    = 4'd1;
  localparam logic [3:0] S_START_LO  = 4'd2;
  localparam logic [3:0] S_REL       = 4'd3;
  localparam logic [3:0] S_ACK_LO    = 4'd4;
  localparam logic [3:0] S_ACK_HI    = 4'd5;
  localparam logic [3:0] S_BIT_LO    = 4'd6;
  localparam logic [3:0] S_BIT_HI    = 4'd7;
  localparam logic [3:0] S_CHECK     = 4'd8;
  localparam logic [3:0] S_WAIT_POLL = 4'd9;

  logic [3:0]      state;
  logic [CHW-1:0]  cur_ch;
  logic [CHW:0]    ch_idx;
  logic [15:0]     tmr;
  logic [31:0]     poll_tmr;
  logic [5:0]      bit_idx;
  logic [39:0]     shreg;
  logic            tmo_flag;
  logic [PW-1:0]   pre_cnt;
  logic            us_tick;
  logic [N_CH-1:0] sync1, sync2, sync3;

  logic [15:0] hum_q  [N_CH];
  logic [15:0] temp_q [N_CH];
  logic [7:0]  crc_q  [N_CH];
  logic [7:0]  err_q  [N_CH];
  logic [N_CH-1:0] vld_q, crc_err_q, tmo_err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_cnt <= '0;
    end else if (pre_cnt == PW'(US_DIV - 1)) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + PW'(1);
    end
  end
  assign us_tick = (pre_cnt == PW'(US_DIV - 1));

  // Idle level of a pulled-up line is 1, so syncs reset high to avoid a phantom edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '1;
      sync2 <= '1;
      sync3 <= '1;
    end else begin
      sync1 <= dht22_in_out;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  logic cur_rise, cur_fall, tmo_hit, start_end;
  assign cur_rise  = sync2[cur_ch] & ~sync3[cur_ch];
  assign cur_fall  = ~sync2[cur_ch] & sync3[cur_ch];
  assign tmo_hit   = us_tick && (tmr == 16'(TIMEOUT_US - 1));
  assign start_end = us_tick && (tmr == 16'(START_US - 1));

  // Lowest enabled channel at or above ch_idx.
  logic           sel_found;
  logic [CHW-1:0] sel_ch;
  always_comb begin
    sel_found = 1'b0;
    sel_ch    = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (ch_mask[i] && (i >= int'(ch_idx))) begin
        sel_found = 1'b1;
        sel_ch    = CHW'(i);
      end
    end
  end

  logic [7:0] crc_calc;
  logic       crc_ok;
  assign crc_calc = shreg[39:32] + shreg[31:24] + shreg[23:16] + shreg[15:8];
  assign crc_ok   = (crc_calc == shreg[7:0]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cur_ch    <= '0;
      ch_idx    <= '0;
      tmr       <= '0;
      poll_tmr  <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      tmo_flag  <= 1'b0;
      done      <= 1'b0;
      done_ch   <= '0;
      vld_q     <= '0;
      crc_err_q <= '0;
      tmo_err_q <= '0;
      for (int i = 0; i < N_CH; i++) begin
        hum_q[i]  <= '0;
        temp_q[i] <= '0;
        crc_q[i]  <= '0;
        err_q[i]  <= '0;
      end
    end else begin
      done <= 1'b0;
      if (us_tick) tmr <= tmr + 16'd1;
      if (us_tick && (poll_tmr < 32'(POLL_US))) poll_tmr <= poll_tmr + 32'd1;

      case (state)
        S_IDLE: begin
          if (enable) begin
            state    <= S_SELECT;
            ch_idx   <= '0;
            poll_tmr <= '0;
          end
        end
        S_SELECT: begin
          if (!enable) begin
            state <= S_IDLE;
          end else if (sel_found) begin
            cur_ch <= sel_ch;
            ch_idx <= {1'b0, sel_ch} + (CHW+1)'(1);
            tmr    <= '0;
            state  <= S_START_LO;
          end else begin
            state <= S_WAIT_POLL;
          end
        end
        S_START_LO: begin
          if (start_end) begin
            tmr   <= '0;
            state <= S_REL;
          end
        end
        S_REL, S_ACK_LO, S_ACK_HI, S_BIT_LO, S_BIT_HI: begin
          if ((state == S_REL || state == S_ACK_HI || state == S_BIT_HI) ? cur_fall : cur_rise) begin
            tmr <= '0;
            case (state)
              S_REL:    state <= S_ACK_LO;
              S_ACK_LO: state <= S_ACK_HI;
              S_ACK_HI: begin
                bit_idx <= '0;
                state   <= S_BIT_LO;
              end
              S_BIT_LO: state <= S_BIT_HI;
              default: begin
                shreg <= {shreg[38:0], (tmr > 16'(BIT_TH_US))};
                if (bit_idx == 6'd39) begin
                  state <= S_CHECK;
                end else begin
                  bit_idx <= bit_idx + 6'd1;
                  state   <= S_BIT_LO;
                end
              end
            endcase
          end else if (tmo_hit) begin
            tmo_flag <= 1'b1;
            state    <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (tmo_flag) begin
            tmo_err_q[cur_ch] <= 1'b1;
            if (err_q[cur_ch] != 8'hFF) err_q[cur_ch] <= err_q[cur_ch] + 8'd1;
          end else if (crc_ok) begin
            hum_q[cur_ch]     <= shreg[39:24];
            temp_q[cur_ch]    <= shreg[23:8];
            crc_q[cur_ch]     <= shreg[7:0];
            vld_q[cur_ch]     <= 1'b1;
            crc_err_q[cur_ch] <= 1'b0;
            tmo_err_q[cur_ch] <= 1'b0;
          end else begin
            crc_err_q[cur_ch] <= 1'b1;
            if (err_q[cur_ch] != 8'hFF) err_q[cur_ch] <= err_q[cur_ch] + 8'd1;
          end
          tmo_flag <= 1'b0;
          done     <= 1'b1;
          done_ch  <= cur_ch;
          state    <= S_SELECT;
        end
        S_WAIT_POLL: begin
          if (poll_tmr >= 32'(POLL_US)) begin
            if (enable) begin
              state    <= S_SELECT;
              ch_idx   <= '0;
              poll_tmr <= '0;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Drive is decoded from registers, so an async reset releases the line immediately.
  for (genvar g = 0; g < N_CH; g++) begin : g_line
    assign dht22_in_out[g] = (state == S_START_LO && cur_ch == CHW'(g)) ? 1'b0 : 1'bz;
  end

  logic busy_rd;
  assign busy_rd        = (state >= S_START_LO) && (state <= S_CHECK) && (cur_ch == rd_ch);
  assign rd_humidity    = hum_q[rd_ch];
  assign rd_temperature = temp_q[rd_ch];
  assign rd_crc         = crc_q[rd_ch];
  assign rd_status      = {err_q[rd_ch], 4'b0, busy_rd, tmo_err_q[rd_ch], crc_err_q[rd_ch], vld_q[rd_ch]};

endmodule

// File: tb/tb_dht22_multi_reader.sv
`timescale 1ns/1ps
// Bench for dht22_multi_reader: behavioural DHT22 sensors on pulled-up lines, scoreboard of per-transaction results.
module tb_dht22_multi_reader;

  logic        clk;
  logic        rst;
  logic        enable;
  logic [3:0]  ch_mask;
  logic [1:0]  rd_ch;
  logic [15:0] rd_humidity, rd_temperature, rd_status;
  logic [7:0]  rd_crc;
  logic        done;
  logic [1:0]  done_ch;
  wire  [3:0]  line;
  logic [3:0]  sens_low;

  for (genvar g = 0; g < 4; g++) begin : g_pu
    pullup (line[g]);
    assign line[g] = sens_low[g] ? 1'b0 : 1'bz;
  end

  dht22_multi_reader #(
    .N_CH(4), .CLK_FREQ(1_000_000), .SIMULATION(1), .POLL_MS(2000),
    .TIMEOUT_US(200), .BIT_TH_US(48)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .ch_mask(ch_mask),
    .dht22_in_out(line), .rd_ch(rd_ch),
    .rd_humidity(rd_humidity), .rd_temperature(rd_temperature),
    .rd_crc(rd_crc), .rd_status(rd_status), .done(done), .done_ch(done_ch)
  );

  initial begin
    clk = 1'b0;
    forever #500 clk = ~clk;
  end

  int n_chk = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, want);
    end
  endtask

  // Monitor: counts DUT-driven low onsets per line and done pulses.
  int cyc = 0;
  int start_n [4] = '{0, 0, 0, 0};
  int start_cyc [4] = '{0, 0, 0, 0};
  int done_n = 0;
  logic [3:0] drv_prev = 4'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (line[i] === 1'b0 && !sens_low[i] && !drv_prev[i]) begin
        start_n[i]   <= start_n[i] + 1;
        start_cyc[i] <= cyc;
      end
      drv_prev[i] <= (line[i] === 1'b0) && !sens_low[i];
    end
    if (done === 1'b1) done_n <= done_n + 1;
  end

  // Sensor model state
  logic [39:0] frame [4];
  bit          present [4];
  bit          sens_active [4];
  int          sens_hi_bit [4];

  task automatic drive_for(input int i, input bit lo, input int n);
    sens_low[i] = lo;
    repeat (n) @(posedge clk);
    #100;
  endtask

  task automatic sensor(input int i);
    int run;
    logic [39:0] f;
    forever begin
      run = 0;
      while (run < 500) begin
        @(negedge clk);
        if (line[i] === 1'b0 && !sens_low[i]) run++;
        else run = 0;
      end
      while (line[i] !== 1'b1) @(negedge clk);
      #100;
      if (present[i]) begin
        f = frame[i];
        sens_active[i] = 1'b1;
        drive_for(i, 1'b0, 20);
        drive_for(i, 1'b1, 80);
        drive_for(i, 1'b0, 80);
        for (int b = 39; b >= 0; b--) begin
          drive_for(i, 1'b1, 30);
          sens_hi_bit[i] = b;
          drive_for(i, 1'b0, f[b] ? 60 : 20);
          sens_hi_bit[i] = -1;
        end
        drive_for(i, 1'b1, 30);
        sens_low[i] = 1'b0;
        sens_active[i] = 1'b0;
      end
    end
  endtask

  // Scoreboard and reference bank model
  typedef struct {
    int          ch;
    logic [15:0] h;
    logic [15:0] t;
    logic [7:0]  c;
    logic [15:0] st;
    bit          lat;
  } want_t;
  want_t sb [$];

  logic [15:0] m_h [4];
  logic [15:0] m_t [4];
  logic [7:0]  m_c [4];
  logic [7:0]  m_err [4];
  bit          m_vld [4];
  bit          m_crc [4];
  bit          m_tmo [4];

  task automatic model_clear();
    for (int i = 0; i < 4; i++) begin
      m_h[i] = '0; m_t[i] = '0; m_c[i] = '0; m_err[i] = '0;
      m_vld[i] = 0; m_crc[i] = 0; m_tmo[i] = 0;
    end
  endtask

  task automatic plan(input int ch, input bit pres, input logic [15:0] h, input logic [15:0] t,
                      input logic [7:0] c, input bit lat);
    want_t e;
    logic [7:0] sum;
    present[ch] = pres;
    frame[ch]   = {h, t, c};
    sum = h[15:8] + h[7:0] + t[15:8] + t[7:0];
    if (!pres) begin
      m_tmo[ch] = 1;
      if (m_err[ch] != 8'hFF) m_err[ch]++;
    end else if (sum == c) begin
      m_h[ch] = h; m_t[ch] = t; m_c[ch] = c;
      m_vld[ch] = 1; m_crc[ch] = 0; m_tmo[ch] = 0;
    end else begin
      m_crc[ch] = 1;
      if (m_err[ch] != 8'hFF) m_err[ch]++;
    end
    e.ch = ch; e.h = m_h[ch]; e.t = m_t[ch]; e.c = m_c[ch]; e.lat = lat;
    e.st = {m_err[ch], 4'b0, 1'b0, m_tmo[ch], m_crc[ch], m_vld[ch]};
    sb.push_back(e);
  endtask

  task automatic expect_dones(input int n);
    want_t e;
    int w;
    for (int k = 0; k < n; k++) begin
      w = 0;
      do begin
        @(negedge clk);
        w++;
      end while (done !== 1'b1 && w < 30000);
      if (done !== 1'b1) begin
        check_eq("done_timeout", 0, 1);
        return;
      end
      if (sb.size() == 0) begin
        check_eq("unexpected_done", 0, 1);
        return;
      end
      e = sb.pop_front();
      check_eq("done_ch", done_ch, e.ch);
      rd_ch = e.ch[1:0];
      #1;
      check_eq($sformatf("hum%0d", e.ch), rd_humidity, e.h);
      check_eq($sformatf("temp%0d", e.ch), rd_temperature, e.t);
      check_eq($sformatf("crc%0d", e.ch), rd_crc, e.c);
      check_eq($sformatf("status%0d", e.ch), rd_status, e.st);
      if (e.lat) check_eq("tmo_latency_le_1202", (cyc - start_cyc[e.ch]) <= 1202, 1);
    end
  endtask

  task automatic check_bank_zero();
    for (int i = 0; i < 4; i++) begin
      rd_ch = 2'(i);
      #1;
      check_eq($sformatf("zero_hum%0d", i), rd_humidity, 0);
      check_eq($sformatf("zero_temp%0d", i), rd_temperature, 0);
      check_eq($sformatf("zero_crc%0d", i), rd_crc, 0);
      check_eq($sformatf("zero_status%0d", i), rd_status, 0);
    end
  endtask

  initial begin
    int w, s1, s3, s0, s2, d;
    rst = 1'b1; enable = 1'b0; ch_mask = 4'hF; rd_ch = '0; sens_low = '0;
    for (int i = 0; i < 4; i++) begin
      present[i] = 1; sens_active[i] = 0; sens_hi_bit[i] = -1; frame[i] = '0;
    end
    model_clear();
    fork
      sensor(0);
      sensor(1);
      sensor(2);
      sensor(3);
    join_none

    repeat (3) @(negedge clk);
    check_eq("rst_done", done, 0);
    check_eq("rst_done_ch", done_ch, 0);
    check_eq("rst_lines", line, 4'hF);
    check_bank_zero();
    @(negedge clk);
    rst = 1'b0;

    // Sweep 1: all channels good
    for (int i = 0; i < 4; i++) plan(i, 1, 16'h01F4, 16'h00FA, 8'hEF, 0);
    enable = 1'b1;
    expect_dones(4);

    // Sweep 2: negative temperature, bad checksum, absent sensor
    plan(0, 1, 16'h01F4, 16'h00FA, 8'hEF, 0);
    plan(1, 1, 16'h0222, 16'h0111, 8'h37, 0);
    plan(2, 1, 16'h01F4, 16'h8065, 8'hDA, 0);
    plan(3, 0, 16'h0000, 16'h0000, 8'h00, 1);
    expect_dones(4);

    // Sweep 3: good frames clear the error flags, err_cnt stays
    for (int i = 0; i < 4; i++) plan(i, 1, 16'h01F4, 16'h00FA, 8'hEF, 0);
    expect_dones(4);

    // Sweep 4: masked sweep, reset while ch0 is mid-frame
    ch_mask = 4'b0101;
    s1 = start_n[1];
    s3 = start_n[3];
    w = 0;
    while (sens_hi_bit[0] != 20 && w < 30000) begin
      @(negedge clk);
      w++;
    end
    check_eq("reach_bit_hi", sens_hi_bit[0] == 20, 1);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    enable = 1'b0;
    #1;
    check_eq("rst_mid_line0", line[0], 1);
    check_eq("rst_mid_done", done, 0);
    model_clear();
    check_bank_zero();
    @(negedge clk);
    rst = 1'b0;
    w = 0;
    while (sens_active[0] && w < 5000) begin
      @(negedge clk);
      w++;
    end
    check_eq("sensor0_idle", sens_active[0], 0);

    // Sweep 5: mask 0101, enable dropped during ch2 frame
    plan(0, 1, 16'h01F4, 16'h00FA, 8'hEF, 0);
    plan(2, 1, 16'h0300, 16'h0123, 8'h27, 0);
    enable = 1'b1;
    expect_dones(1);
    w = 0;
    while (sens_hi_bit[2] < 0 && w < 10000) begin
      @(negedge clk);
      w++;
    end
    enable = 1'b0;
    expect_dones(1);
    d  = done_n;
    s0 = start_n[0];
    s2 = start_n[2];
    repeat (3000) @(negedge clk);
    check_eq("no_done_after_disable", done_n - d, 0);
    check_eq("no_start_after_disable", (start_n[0] - s0) + (start_n[2] - s2), 0);
    check_eq("line1_never_driven", start_n[1] - s1, 0);
    check_eq("line3_never_driven", start_n[3] - s3, 0);
    check_eq("scoreboard_drained", sb.size(), 0);

    // Reset during the start pulse releases the line without waiting for a clock edge
    ch_mask = 4'b0001;
    s0 = start_n[0];
    enable = 1'b1;
    w = 0;
    while (start_n[0] == s0 && w < 100) begin
      @(negedge clk);
      w++;
    end
    repeat (10) @(negedge clk);
    #200;
    check_eq("start_lo_driving", line[0], 0);
    rst = 1'b1;
    enable = 1'b0;
    #1;
    check_eq("async_release", line[0], 1);
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
